// File: rtl/revelador_casillas.sv
// Player-side reader of the minesweeper board.
// Consumes reveal/flag requests against a board (bomb positions plus
// per-cell neighbour counts) supplied by the board generator. It keeps the
// revealed and flagged masks, uncovers zero-count regions with a FIFO
// flood fill, and raises sticky loss/win indications.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   bomb_map[N]         1 = bomb in cell i (i = fila*COLUMNAS + col)
//   adj_count[4N]       neighbour-bomb count of cell i at [4i+3:4i]
//   req_valid/ready     request handshake; ready only while idle
//   req_fila, req_col   target cell
//   req_flag            1 = toggle flag, 0 = reveal
//   revealed, flagged   cell masks
//   busy                flood/check in progress
//   game_over, game_won sticky until reset
//   reveal_count        revealed safe cells
module revelador_casillas #(
  parameter int FILAS    = 8,
  parameter int COLUMNAS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FILAS*COLUMNAS-1:0]     bomb_map,
  input  logic [4*FILAS*COLUMNAS-1:0]   adj_count,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [2:0]                    req_fila,
  input  logic [2:0]                    req_col,
  input  logic                          req_flag,
  output logic [FILAS*COLUMNAS-1:0]     revealed,
  output logic [FILAS*COLUMNAS-1:0]     flagged,
  output logic                          busy,
  output logic                          game_over,
  output logic                          game_won,
  output logic [6:0]                    reveal_count
);

  localparam int N     = FILAS * COLUMNAS;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = 7;

  localparam logic [IDX_W-1:0] COLS_I    = IDX_W'(COLUMNAS);
  localparam logic [2:0]       LAST_FILA = 3'(FILAS - 1);
  localparam logic [2:0]       LAST_COL  = 3'(COLUMNAS - 1);

  typedef enum logic [2:0] {IDLE, CHECK, POP, SCAN, LOST, WON} state_t;

  state_t             state;
  logic [IDX_W-1:0]   mem [N];
  logic [IDX_W-1:0]   head, tail;
  logic [IDX_W:0]     q_count;
  logic [2:0]         k;
  logic [2:0]         p_fila, p_col;

  logic [IDX_W-1:0]   req_idx, nb_idx, push_idx, head_entry;
  logic [2:0]         nb_fila, nb_col;
  logic               accept, req_safe, nb_ok, scan_take, push_en, pop_en;
  logic               up, down, left, right;
  logic [CNT_W-1:0]   bomb_total, safe_total;

  function automatic logic adj_is_zero(input logic [4*FILAS*COLUMNAS-1:0] adj,
                                       input logic [IDX_W-1:0] i);
    return adj[{i, 2'b00} +: 4] == 4'd0;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(N - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign head_entry = mem[head];

  assign req_idx  = IDX_W'(req_fila) * COLS_I + IDX_W'(req_col);
  assign accept   = req_valid && (state == IDLE);
  assign req_safe = accept && !req_flag && !revealed[req_idx] &&
                    !flagged[req_idx] && !bomb_map[req_idx];

  // Neighbour k of the cell being scanned: NW,N,NE,W,E,SW,S,SE.
  always_comb begin
    up    = (k <= 3'd2);
    down  = (k >= 3'd5);
    left  = (k == 3'd0) || (k == 3'd3) || (k == 3'd5);
    right = (k == 3'd2) || (k == 3'd4) || (k == 3'd7);
  end

  // Edge cells have no neighbour on that side; no wrap-around.
  assign nb_ok = !(up && p_fila == 3'd0) && !(down && p_fila == LAST_FILA) &&
                 !(left && p_col == 3'd0) && !(right && p_col == LAST_COL);
  assign nb_fila = up ? p_fila - 3'd1 : (down ? p_fila + 3'd1 : p_fila);
  assign nb_col  = left ? p_col - 3'd1 : (right ? p_col + 3'd1 : p_col);
  assign nb_idx  = IDX_W'(nb_fila) * COLS_I + IDX_W'(nb_col);

  assign scan_take = (state == SCAN) && nb_ok && !revealed[nb_idx] &&
                     !flagged[nb_idx] && !bomb_map[nb_idx];

  // A cell is marked revealed when pushed, so the queue never overflows.
  assign push_en  = (req_safe && adj_is_zero(adj_count, req_idx)) ||
                    (scan_take && adj_is_zero(adj_count, nb_idx));
  assign push_idx = (state == SCAN) ? nb_idx : req_idx;
  assign pop_en   = (state == POP);

  always_comb begin
    bomb_total = '0;
    for (int i = 0; i < N; i++) bomb_total = bomb_total + CNT_W'(bomb_map[i]);
  end
  assign safe_total = CNT_W'(N) - bomb_total;

  // Queue storage
  always_ff @(posedge clk) begin
    if (push_en) mem[tail] <= push_idx;
  end

  // Control FSM and board state
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      revealed     <= '0;
      flagged      <= '0;
      game_over    <= 1'b0;
      game_won     <= 1'b0;
      reveal_count <= '0;
      head         <= '0;
      tail         <= '0;
      q_count      <= '0;
      k            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_flag) begin
              if (!revealed[req_idx]) flagged[req_idx] <= ~flagged[req_idx];
            end else if (!revealed[req_idx] && !flagged[req_idx]) begin
              if (bomb_map[req_idx]) begin
                revealed  <= revealed | bomb_map;
                game_over <= 1'b1;
                state     <= LOST;
              end else begin
                revealed[req_idx] <= 1'b1;
                reveal_count      <= reveal_count + CNT_W'(1);
                state             <= CHECK;
              end
            end
          end
        end
        CHECK: begin
          if (q_count != '0) begin
            state <= POP;
          end else if (reveal_count == safe_total) begin
            game_won <= 1'b1;
            state    <= WON;
          end else begin
            state <= IDLE;
          end
        end
        POP: begin
          p_fila <= 3'(head_entry / COLS_I);
          p_col  <= 3'(head_entry % COLS_I);
          head   <= next_ptr(head);
          k      <= '0;
          state  <= SCAN;
        end
        SCAN: begin
          if (scan_take) begin
            revealed[nb_idx] <= 1'b1;
            reveal_count     <= reveal_count + CNT_W'(1);
          end
          k <= k + 3'd1;
          if (k == 3'd7) state <= CHECK;
        end
        LOST: state <= LOST;
        WON:  state <= WON;
        default: state <= IDLE;
      endcase

      if (push_en) begin
        tail    <= next_ptr(tail);
        q_count <= q_count + (IDX_W+1)'(1);
      end else if (pop_en) begin
        q_count <= q_count - (IDX_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_revelador_casillas.sv
// Self-checking bench for revelador_casillas: directed scenarios plus
// random boards and requests, compared against a closure-based model of
// the reveal rules.
module tb_revelador_casillas;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  bomb_map = '0;
  logic [255:0] adj_count = '0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_fila = '0;
  logic [2:0]   req_col = '0;
  logic         req_flag = 1'b0;
  logic [63:0]  revealed, flagged;
  logic         busy, game_over, game_won;
  logic [6:0]   reveal_count;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_bombs, m_rev, m_flag;
  int          m_count;
  bit          m_over, m_won;

  revelador_casillas #(.FILAS(8), .COLUMNAS(8)) dut (
    .clk(clk), .reset(reset), .bomb_map(bomb_map), .adj_count(adj_count),
    .req_valid(req_valid), .req_ready(req_ready), .req_fila(req_fila),
    .req_col(req_col), .req_flag(req_flag), .revealed(revealed),
    .flagged(flagged), .busy(busy), .game_over(game_over),
    .game_won(game_won), .reveal_count(reveal_count)
  );

  always #5 clk = ~clk;

  function automatic int adj_of(input logic [63:0] b, input int i);
    int r, c, n;
    r = i / 8; c = i % 8; n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < 8 && c+dc >= 0 && c+dc < 8)
          if (b[(r+dr)*8 + c+dc]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loads a new board (only while reset is held) and clears the model.
  task automatic do_reset(input logic [63:0] b);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0;
    bomb_map = b;
    for (int i = 0; i < 64; i++) adj_count[4*i +: 4] = 4'(adj_of(b, i));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_bombs = b; m_rev = '0; m_flag = '0; m_count = 0; m_over = 0; m_won = 0;
  endtask

  // Model: applies one request; returns expected busy edges after accept.
  task automatic model_req(input int f, input int c, input bit fl, output int exp_cyc);
    int idx, z;
    bit changed;
    logic [63:0] newm, done;
    exp_cyc = 0;
    idx = f*8 + c;
    if (m_over || m_won) return;
    if (fl) begin
      if (!m_rev[idx]) m_flag[idx] = ~m_flag[idx];
      return;
    end
    if (m_rev[idx] || m_flag[idx]) return;
    if (m_bombs[idx]) begin
      m_rev = m_rev | m_bombs;
      m_over = 1;
      return;
    end
    newm = '0; done = '0; z = 0;
    m_rev[idx] = 1'b1; newm[idx] = 1'b1; m_count++;
    changed = 1;
    while (changed) begin
      changed = 0;
      for (int i = 0; i < 64; i++) begin
        if (newm[i] && !done[i] && adj_of(m_bombs, i) == 0) begin
          done[i] = 1'b1; z++; changed = 1;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
              int r, cc, q;
              r = i/8 + dr; cc = i%8 + dc;
              if (!(dr == 0 && dc == 0) && r >= 0 && r < 8 && cc >= 0 && cc < 8) begin
                q = r*8 + cc;
                if (!m_rev[q] && !m_flag[q] && !m_bombs[q]) begin
                  m_rev[q] = 1'b1; newm[q] = 1'b1; m_count++;
                end
              end
            end
        end
      end
    end
    exp_cyc = 1 + 10*z;
    if (m_count == 64 - $countones(m_bombs)) m_won = 1;
  endtask

  task automatic issue(input int f, input int c, input bit fl);
    @(negedge clk);
    req_fila = 3'(f); req_col = 3'(c); req_flag = fl; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!(req_ready || game_won || game_over) && cyc < 1000) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic step(input int f, input int c, input bit fl, input string tag);
    int exp_cyc, cyc;
    model_req(f, c, fl, exp_cyc);
    issue(f, c, fl);
    wait_done(cyc);
    chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_revealed"}, revealed, m_rev);
    chk({tag, "_flagged"}, flagged, m_flag);
    chk({tag, "_count"}, 64'(reveal_count), 64'(m_count));
    chk({tag, "_over"}, 64'(game_over), 64'(m_over));
    chk({tag, "_won"}, 64'(game_won), 64'(m_won));
    chk({tag, "_ready"}, 64'(req_ready), 64'(!(m_over || m_won)));
  endtask

  initial begin
    logic [63:0] b;
    int cyc;

    // Reset state
    do_reset(64'h0);
    #1;
    chk("rst_revealed", revealed, 64'h0);
    chk("rst_flagged", flagged, 64'h0);
    chk("rst_count", 64'(reveal_count), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_over", 64'(game_over), 64'd0);
    chk("rst_won", 64'(game_won), 64'd0);

    // Single non-zero reveal: one busy cycle
    do_reset(64'h1);
    issue(0, 1, 1'b0);
    chk("t2_busy_hi", 64'(busy), 64'd1);
    chk("t2_ready_lo", 64'(req_ready), 64'd0);
    chk("t2_revealed", revealed, 64'h2);
    chk("t2_count", 64'(reveal_count), 64'd1);
    @(posedge clk); #1;
    chk("t2_busy_lo", 64'(busy), 64'd0);
    chk("t2_ready_hi", 64'(req_ready), 64'd1);

    // Full-board flood to a win
    do_reset(64'h1 << 63);
    step(0, 0, 1'b0, "t3_flood");
    repeat (5) @(posedge clk);
    #1;
    chk("t3_ready_stays_lo", 64'(req_ready), 64'd0);
    step(1, 1, 1'b1, "t3_after_win");

    // Bomb hit
    b = (64'h1 << 5) | (64'h1 << 20) | (64'h1 << 40);
    do_reset(b);
    step(2, 4, 1'b0, "t4_bomb");
    step(0, 0, 1'b0, "t4_after_loss");

    // Flag handling
    do_reset(b);
    step(3, 3, 1'b1, "t5_flag");
    step(3, 3, 1'b0, "t5_reveal_flagged");
    step(3, 3, 1'b1, "t5_unflag");
    step(3, 3, 1'b0, "t5_reveal");
    step(3, 3, 1'b1, "t5_flag_revealed");

    // Reset during a flood
    do_reset(64'h1 << 63);
    issue(0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_mid_busy", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_revealed", revealed, 64'h0);
    chk("t6_flagged", flagged, 64'h0);
    chk("t6_count", 64'(reveal_count), 64'd0);
    chk("t6_ready", 64'(req_ready), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Random boards and requests
    for (int bd = 0; bd < 6; bd++) begin
      b = '0;
      for (int i = 0; i < 64; i++) b[i] = ($urandom_range(0, 99) < 10 + 3*bd);
      do_reset(b);
      for (int r = 0; r < 25; r++)
        step($urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 3) == 0),
             $sformatf("rnd_b%0d_r%0d", bd, r));
    end

    // Settle time before wrapping up
    wait_done(cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
